// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
// Shared constants and types for the 8-way round-robin arbiter.
//   N_REQ   : number of requesters (fixed at 8)
//   IDX_W   : width of a requester index (log2 of N_REQ)
//   idx_t   : requester index type
//   state_e : arbiter FSM states (IDLE, GRANT, GAP)
// ---------------------------------------------------------------------------
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/dec3to8_en.sv
// ---------------------------------------------------------------------------
// dec3to8_en
// Combinational 3-to-8 one-hot decoder with enable.
// Ports:
//   idx [2:0] : index to decode
//   en        : when 0 the output is all zero
//   y   [7:0] : one-hot of idx when en=1, else zero
// ---------------------------------------------------------------------------
module dec3to8_en
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// rr_arbiter_8
// Round-robin arbiter sharing one resource among 8 requesters. A winner keeps
// its grant until it drops its request or HOLD_MAX grant cycles elapse; every
// grant is followed by one idle GAP cycle so grants never overlap.
//
// Request/grant handshake: requester i raises req[i] and keeps it high for as
// long as it wants or uses the resource; it owns the resource exactly while
// gnt[i]=1. Dropping req[i] releases the resource; gnt falls one cycle later.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   req [7:0] : request vector
//   gnt [7:0] : one-hot grant, zero when no grant is active
//   gnt_idx   : index of current or last granted requester
//   gnt_valid : high while a grant is active
//   timeout   : one-cycle pulse when a grant is revoked by HOLD_MAX
//   dbg_state : current FSM state (state_e encoding)
//
// Parameter HOLD_MAX: maximum consecutive grant cycles, 0 disables the limit.
// Build option RR_ARB_PRIO0_EN: requester 0 wins every arbitration it takes
// part in (never preempts an active grant); the pointer still rotates.
// ---------------------------------------------------------------------------
module rr_arbiter_8
    import rr_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout,
    output logic [1:0]       dbg_state
);

    localparam int unsigned     CNT_W      = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic             TIMEOUT_EN = (HOLD_MAX != 0);

    state_e           state_q, state_d;
    idx_t             idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    idx_t             ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    idx_t             win;

    // First set bit of r scanning p, p+1, ... with 3-bit wraparound.
    function automatic idx_t rr_pick(input logic [N_REQ-1:0] r, input idx_t p);
        idx_t pick;
        idx_t cand;
        logic found;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = p + idx_t'(i);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
`ifdef RR_ARB_PRIO0_EN
        win = req[0] ? idx_t'(0) : rr_pick(req, ptr_q);
`else
        win = rr_pick(req, ptr_q);
`endif
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE, GAP: begin
                valid_d = 1'b0;
                state_d = IDLE;
                if (|req) begin
                    idx_d   = win;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + CNT_W'(1);
                // A voluntary drop wins over a coinciding timeout.
                if (!req[idx_q]) begin
                    valid_d = 1'b0;
                    ptr_d   = idx_q + idx_t'(1);
                    state_d = GAP;
                end else if (TIMEOUT_EN && (hold_q == HOLD_LAST)) begin
                    valid_d   = 1'b0;
                    ptr_d     = idx_q + idx_t'(1);
                    timeout_d = 1'b1;
                    state_d   = GAP;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    dec3to8_en u_dec (
        .idx (idx_q),
        .en  (valid_q),
        .y   (gnt)
    );

    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_8
// Bench for rr_arbiter_8. A behavioural model tracks owner / pointer / cycles
// held as plain integers and is stepped once per clock from the same inputs
// driven to the design. Honours RR_ARB_PRIO0_EN like the design.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_8;
    import rr_arb_pkg::*;

    localparam int HOLD_MAX = 15;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    logic [1:0] dbg_state;

    int checks = 0;
    int fails  = 0;

    // Reference model state.
    bit m_active;
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    rr_arbiter_8 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic int model_pick(input logic [7:0] r);
`ifdef RR_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int off = 0; off < 8; off++) begin
            if (r[(m_ptr + off) % 8]) return (m_ptr + off) % 8;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [7:0] r, input logic rs);
        int p;
        m_to = 1'b0;
        if (rs) begin
            m_active = 1'b0;
            m_owner  = 0;
            m_ptr    = 0;
            m_held   = 0;
        end else if (m_active) begin
            m_held = m_held + 1;
            if (!r[m_owner] || (HOLD_MAX != 0 && m_held == HOLD_MAX)) begin
                m_to     = r[m_owner];
                m_active = 1'b0;
                m_ptr    = (m_owner + 1) % 8;
            end
        end else begin
            p = model_pick(r);
            if (p >= 0) begin
                m_active = 1'b1;
                m_owner  = p;
                m_held   = 0;
            end
        end
    endtask

    // {gnt, gnt_valid, gnt_idx, timeout} the model expects right now.
    function automatic logic [12:0] exp_vec();
        logic [7:0] g;
        g = m_active ? (8'h01 << m_owner) : 8'h00;
        return {g, m_active, 3'(m_owner), m_to};
    endfunction

    // ---------------- driver ----------------
    task automatic tick(input logic [7:0] r, input logic rs);
        @(negedge clk);
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick(8'h00, 1'b1);
        tick(8'h00, 1'b1);
        checks++;
        if (dbg_state !== IDLE) begin
            fails++;
            $display("FAIL reset_state: got %0d exp %0d", dbg_state, IDLE);
        end
        for (int i = 0; i < 5; i++) begin
            tick(8'h00, 1'b0);
            checks++;
            if ({gnt, gnt_valid, gnt_idx, timeout} !== 13'h0) begin
                fails++;
                $display("FAIL reset_idle cyc %0d: got gnt=%h v=%b idx=%0d to=%b exp all zero",
                         i, gnt, gnt_valid, gnt_idx, timeout);
            end
        end
    endtask

    task automatic test_basic();
        tick(8'h24, 1'b0);
        checks++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
            fails++;
            $display("FAIL basic_first: got gnt=%h idx=%0d v=%b exp gnt=04 idx=2 v=1", gnt, gnt_idx, gnt_valid);
        end
        tick(8'h24, 1'b0);
        tick(8'h24, 1'b0);
        checks++;
        if ({gnt, gnt_valid, gnt_idx, timeout} !== exp_vec()) begin
            fails++;
            $display("FAIL basic_hold: got %h exp %h", {gnt, gnt_valid, gnt_idx, timeout}, exp_vec());
        end
        tick(8'h20, 1'b0);
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL basic_gap: got gnt=%h v=%b to=%b exp gnt=00 v=0 to=0", gnt, gnt_valid, timeout);
        end
        tick(8'h20, 1'b0);
        checks++;
        if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
            fails++;
            $display("FAIL basic_second: got gnt=%h idx=%0d exp gnt=20 idx=5", gnt, gnt_idx);
        end
        for (int i = 0; i < 2; i++) begin
            tick(8'h00, 1'b0);
            checks++;
            if ({gnt, gnt_valid, gnt_idx, timeout} !== exp_vec()) begin
                fails++;
                $display("FAIL basic_idle: got %h exp %h", {gnt, gnt_valid, gnt_idx, timeout}, exp_vec());
            end
        end
    endtask

    task automatic test_rotation();
        int order[$];
        int runs[$];
        int run;
        int to_cnt;
        logic prev_v;
        run    = 0;
        to_cnt = 0;
        prev_v = 1'b0;
        tick(8'hFF, 1'b1);
        for (int i = 0; i < 129; i++) begin
            tick(8'hFF, 1'b0);
            checks++;
            if ({gnt, gnt_valid, gnt_idx, timeout} !== exp_vec()) begin
                fails++;
                $display("FAIL rotation cyc %0d: got %h exp %h", i, {gnt, gnt_valid, gnt_idx, timeout}, exp_vec());
            end
            if (gnt_valid && !prev_v) order.push_back(int'(gnt_idx));
            if (gnt_valid) run++;
            if (!gnt_valid && prev_v) begin
                runs.push_back(run);
                run = 0;
            end
            if (timeout) to_cnt++;
            prev_v = gnt_valid;
        end
        checks++;
        if (order.size() != 9) begin
            fails++;
            $display("FAIL rotation_count: got %0d grants exp 9", order.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (order[k] != k % 8) begin
                    fails++;
                    $display("FAIL rotation_order[%0d]: got %0d exp %0d", k, order[k], k % 8);
                end
            end
        end
        foreach (runs[k]) begin
            checks++;
            if (runs[k] != HOLD_MAX) begin
                fails++;
                $display("FAIL rotation_len[%0d]: got %0d exp %0d", k, runs[k], HOLD_MAX);
            end
        end
        checks++;
        if (to_cnt != 8 || runs.size() != 8) begin
            fails++;
            $display("FAIL rotation_timeouts: got %0d pulses / %0d runs exp 8 / 8", to_cnt, runs.size());
        end
    endtask

    task automatic test_wrap();
        tick(8'h00, 1'b1);
        tick(8'h80, 1'b0);
        tick(8'h81, 1'b0);
        tick(8'h81, 1'b0);
        checks++;
        if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
            fails++;
            $display("FAIL wrap_hold: got gnt=%h idx=%0d exp gnt=80 idx=7", gnt, gnt_idx);
        end
        tick(8'h01, 1'b0);
        checks++;
        if ({gnt, gnt_valid, gnt_idx, timeout} !== exp_vec()) begin
            fails++;
            $display("FAIL wrap_gap: got %h exp %h", {gnt, gnt_valid, gnt_idx, timeout}, exp_vec());
        end
        tick(8'h01, 1'b0);
        checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            fails++;
            $display("FAIL wrap_next: got gnt=%h idx=%0d exp gnt=01 idx=0", gnt, gnt_idx);
        end
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
    endtask

    task automatic test_reset_mid();
        tick(8'h00, 1'b1);
        tick(8'h08, 1'b0);
        tick(8'h08, 1'b0);
        checks++;
        if (gnt !== 8'h08) begin
            fails++;
            $display("FAIL midrst_pre: got gnt=%h exp 08", gnt);
        end
        tick(8'h08, 1'b1);
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || dbg_state !== IDLE) begin
            fails++;
            $display("FAIL midrst_drop: got gnt=%h v=%b idx=%0d st=%0d exp 00/0/0/0",
                     gnt, gnt_valid, gnt_idx, dbg_state);
        end
        tick(8'h0C, 1'b0);
        checks++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2) begin
            fails++;
            $display("FAIL midrst_after: got gnt=%h idx=%0d exp gnt=04 idx=2", gnt, gnt_idx);
        end
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
    endtask

    task automatic test_prio();
        logic [7:0] want;
`ifdef RR_ARB_PRIO0_EN
        want = 8'h01;
`else
        want = 8'h08;
`endif
        tick(8'h00, 1'b1);
        tick(8'h04, 1'b0);
        tick(8'h00, 1'b0);
        tick(8'h09, 1'b0);
        checks++;
        if (gnt !== want) begin
            fails++;
            $display("FAIL prio0: got gnt=%h exp %h", gnt, want);
        end
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
    endtask

    task automatic test_timeout_edge();
        tick(8'h00, 1'b1);
        tick(8'h01, 1'b0);
        for (int i = 0; i < HOLD_MAX - 1; i++) tick(8'h01, 1'b0);
        // Drop coincides with the hold limit: voluntary release.
        tick(8'h00, 1'b0);
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL to_voluntary: got v=%b to=%b exp v=0 to=0", gnt_valid, timeout);
        end
        tick(8'h01, 1'b0);
        for (int i = 0; i < HOLD_MAX - 1; i++) tick(8'h01, 1'b0);
        checks++;
        if (gnt !== 8'h01 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL to_last_cycle: got gnt=%h to=%b exp gnt=01 to=0", gnt, timeout);
        end
        tick(8'h01, 1'b0);
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b1) begin
            fails++;
            $display("FAIL to_pulse: got gnt=%h to=%b exp gnt=00 to=1", gnt, timeout);
        end
        // Timed-out requester 0 still asks but requester 1 is now ahead.
        tick(8'h03, 1'b0);
        checks++;
        if (gnt !== 8'h02 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL to_reeligible: got gnt=%h to=%b exp gnt=02 to=0", gnt, timeout);
        end
        tick(8'h00, 1'b0);
        tick(8'h00, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] cur;
        logic       rs;
        cur = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) cur = 8'($urandom);
            if ($urandom_range(0, 15) == 0) cur = 8'h00;
            rs = ($urandom_range(0, 99) == 0);
            tick(cur, rs);
            checks++;
            if ({gnt, gnt_valid, gnt_idx, timeout} !== exp_vec()) begin
                fails++;
                $display("FAIL random cyc %0d req=%h: got %h exp %h",
                         i, cur, {gnt, gnt_valid, gnt_idx, timeout}, exp_vec());
            end
            checks++;
            if (gnt_valid ? (gnt !== (8'h01 << gnt_idx)) : (gnt !== 8'h00)) begin
                fails++;
                $display("FAIL onehot cyc %0d: got gnt=%h v=%b idx=%0d", i, gnt, gnt_valid, gnt_idx);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst      = 1'b1;
        req      = 8'h00;
        m_active = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_held   = 0;
        m_to     = 1'b0;
        test_reset();
        test_basic();
        test_rotation();
        test_wrap();
        test_reset_mid();
        test_prio();
        test_timeout_edge();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
